// File: rtl/apb_arbiter_if.sv
// rtl/apb_arbiter_if.sv - APB master bus bundle shared by the arbiter and its slave
interface apb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-requester round-robin arbiter driving one APB master port
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_done,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_done,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  busy,
  apb_arbiter_if.master         apb
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  grant;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;

  logic                  elig0;
  logic                  elig1;
  logic                  pick;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic                  finish;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;

  // A requester whose done is high this cycle is still holding req from the
  // finished transfer, so it must not be re-granted on that same cycle.
  assign elig0 = r0_req && !r0_done;
  assign elig1 = r1_req && !r1_done;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    pick = 1'b0;
    if (elig0 && elig1) begin
      pick = ~last_grant;
    end else if (elig1) begin
      pick = 1'b1;
    end
  end

  assign sel_addr  = pick ? r1_addr  : r0_addr;
  assign sel_wdata = pick ? r1_wdata : r0_wdata;
  assign sel_write = pick ? r1_write : r0_write;

  // Transfer ends on pready, or on the last allowed ACCESS cycle; pready wins.
  assign finish     = apb.pready || (cnt == CW'(TIMEOUT - 1));
  assign resp_rdata = (apb.pready && !pwrite_q) ? apb.prdata : '0;
  assign resp_err   = apb.pready ? apb.pslverr : 1'b1;

  // Arbitration FSM with all bus and response outputs registered.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      busy       <= 1'b0;
      r0_done    <= 1'b0;
      r0_rdata   <= '0;
      r0_err     <= 1'b0;
      r1_done    <= 1'b0;
      r1_rdata   <= '0;
      r1_err     <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            state      <= SETUP;
            grant      <= pick;
            last_grant <= pick;
            paddr_q    <= sel_addr;
            pwrite_q   <= sel_write;
            pwdata_q   <= sel_write ? sel_wdata : '0;
            psel_q     <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
          cnt       <= '0;
        end
        ACCESS: begin
          if (finish) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy      <= 1'b0;
            if (grant) begin
              r1_done  <= 1'b1;
              r1_rdata <= resp_rdata;
              r1_err   <= resp_err;
            end else begin
              r0_done  <= 1'b1;
              r0_rdata <= resp_rdata;
              r0_err   <= resp_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - randomized scoreboard bench for apb_arbiter
module tb_apb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;
  localparam int NTX = 30;

  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk;
  logic hreset;
  logic req_v [2];
  logic wr_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] wd_v [2];
  logic d0, d1, e0o, e1o, busy;
  logic [31:0] rd0, rd1;

  apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if ();

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .hclk(clk), .hreset(hreset),
    .r0_req(req_v[0]), .r0_write(wr_v[0]), .r0_addr(addr_v[0]), .r0_wdata(wd_v[0]),
    .r0_done(d0), .r0_rdata(rd0), .r0_err(e0o),
    .r1_req(req_v[1]), .r1_write(wr_v[1]), .r1_addr(addr_v[1]), .r1_wdata(wd_v[1]),
    .r1_done(d1), .r1_rdata(rd1), .r1_err(e1o),
    .busy(busy), .apb(apb_if.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference-model state: outstanding requests and when they became visible.
  bit pend [2];
  int assert_cyc [2];
  bit masked [2];
  bit mlast;
  bit force_wait;
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit elig(input int k);
    return pend[k] && (assert_cyc[k] <= cyc - 1) && !(masked[k] && assert_cyc[k] == cyc - 1);
  endfunction

  task automatic issue(input int k, input bit m);
    wr_v[k]       = 1'($urandom_range(1, 0));
    addr_v[k]     = $urandom;
    wd_v[k]       = $urandom;
    assert_cyc[k] = cyc;
    masked[k]     = m;
    pend[k]       = 1'b1;
    req_v[k]      = 1'b1;
  endtask

  task automatic run_req(input int k, input int n);
    bit jd;
    bit dn;
    int t;
    int gap;
    jd = 1'b0;
    for (int i = 0; i < n; i++) begin
      issue(k, jd);
      t = 0;
      dn = 1'b0;
      while (!dn && t < 300) begin
        @(negedge clk);
        t++;
        dn = (k == 0) ? d0 : d1;
      end
      chk(dn, "done_wait_bound", 64'(dn), 64'd1);
      if (!dn) begin
        req_v[k] = 1'b0;
        pend[k] = 1'b0;
        break;
      end
      gap = $urandom_range(2, 0);
      if (gap == 0 && i < n - 1) begin
        jd = 1'b1;
      end else begin
        req_v[k] = 1'b0;
        jd = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    req_v[k] = 1'b0;
  endtask

  // APB slave plus arbitration reference: predicts each grant and its response.
  bit prev_psel, prev_setup;
  int w, acc, g;
  bit m0, m1;
  logic [31:0] cap_addr, cap_wdata, cap_prdata;
  bit cap_write, cap_err;
  exp_t ex;

  always @(negedge clk) begin
    if (hreset) begin
      mlast = 1'b1;
      prev_psel = 1'b0;
      prev_setup = 1'b0;
      apb_if.pready = 1'b0;
      acc = 0;
    end else begin
      apb_if.pready = 1'b0;
      apb_if.prdata = $urandom;
      apb_if.pslverr = 1'b0;
      if (prev_setup) chk(apb_if.psel && apb_if.penable, "setup_one_cycle", 64'(apb_if.penable), 64'd1);
      prev_setup = 1'b0;
      if (!prev_psel) begin
        m0 = elig(0);
        m1 = elig(1);
        if (m0 || m1) begin
          g = (m0 && m1) ? (mlast ? 0 : 1) : (m0 ? 0 : 1);
          chk(apb_if.psel && !apb_if.penable, "grant_latency", 64'(apb_if.psel), 64'd1);
          if (apb_if.psel) begin
            cap_write = wr_v[g];
            cap_addr  = addr_v[g];
            cap_wdata = wr_v[g] ? wd_v[g] : 32'd0;
            chk(apb_if.paddr == cap_addr, "grant_paddr", 64'(apb_if.paddr), 64'(cap_addr));
            chk(apb_if.pwrite == cap_write, "grant_pwrite", 64'(apb_if.pwrite), 64'(cap_write));
            chk(apb_if.pwdata == cap_wdata, "grant_pwdata", 64'(apb_if.pwdata), 64'(cap_wdata));
            mlast = g[0];
            pend[g] = 1'b0;
            case ($urandom_range(7, 0))
              0: w = TO;
              1: w = TO - 1;
              default: w = $urandom_range(2, 0);
            endcase
            if (force_wait) w = 1000;
            cap_prdata = $urandom;
            cap_err = ($urandom_range(3, 0) == 0);
            if (w < TO) begin
              ex.rd = cap_write ? 32'd0 : cap_prdata;
              ex.err = cap_err;
              ex.cyc = cyc + w + 2;
            end else begin
              ex.rd = 32'd0;
              ex.err = 1'b1;
              ex.cyc = cyc + TO + 1;
            end
            if (g == 0) exp_q0.push_back(ex); else exp_q1.push_back(ex);
            acc = 0;
            prev_setup = 1'b1;
          end
        end else begin
          chk(!apb_if.psel, "spurious_setup", 64'(apb_if.psel), 64'd0);
        end
      end else if (apb_if.psel && apb_if.penable) begin
        chk(acc < TO, "access_length", 64'(acc), 64'(TO - 1));
        chk(apb_if.paddr == cap_addr && apb_if.pwdata == cap_wdata && apb_if.pwrite == cap_write,
            "access_stable", 64'(apb_if.paddr), 64'(cap_addr));
        apb_if.pready = (acc == w);
        if (acc == w) begin
          apb_if.prdata = cap_prdata;
          apb_if.pslverr = cap_err;
        end
        acc++;
      end
      prev_psel = apb_if.psel;
    end
  end

  // Scoreboard monitor: every done pulse pops and checks one expectation.
  exp_t got;
  always @(negedge clk) begin
    if (!hreset) begin
      chk(!(d0 && d1), "done_exclusive", {d1, d0}, 64'd0);
      chk(busy == apb_if.psel, "busy_track", 64'(busy), 64'(apb_if.psel));
      if (d0) begin
        chk(exp_q0.size() != 0, "r0_unexpected_done", 64'(d0), 64'd0);
        if (exp_q0.size() != 0) begin
          got = exp_q0.pop_front();
          chk(rd0 == got.rd, "r0_rdata", 64'(rd0), 64'(got.rd));
          chk(e0o == got.err, "r0_err", 64'(e0o), 64'(got.err));
          chk(cyc == got.cyc, "r0_done_cycle", 64'(cyc), 64'(got.cyc));
        end
      end
      if (d1) begin
        chk(exp_q1.size() != 0, "r1_unexpected_done", 64'(d1), 64'd0);
        if (exp_q1.size() != 0) begin
          got = exp_q1.pop_front();
          chk(rd1 == got.rd, "r1_rdata", 64'(rd1), 64'(got.rd));
          chk(e1o == got.err, "r1_err", 64'(e1o), 64'(got.err));
          chk(cyc == got.cyc, "r1_done_cycle", 64'(cyc), 64'(got.cyc));
        end
      end
    end
  end

  bit got0, got1;
  initial begin
    hreset = 1'b1;
    force_wait = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0; wr_v[k] = 1'b0; addr_v[k] = '0; wd_v[k] = '0;
      pend[k] = 1'b0; assert_cyc[k] = 0; masked[k] = 1'b0;
    end
    apb_if.pready = 1'b0;
    apb_if.prdata = '0;
    apb_if.pslverr = 1'b0;
    #1;
    chk(!apb_if.psel && !apb_if.penable, "reset_psel_penable", {apb_if.psel, apb_if.penable}, 64'd0);
    chk(apb_if.paddr == 0 && apb_if.pwdata == 0 && !apb_if.pwrite, "reset_bus", 64'(apb_if.paddr), 64'd0);
    chk(!busy, "reset_busy", 64'(busy), 64'd0);
    chk(!d0 && !d1, "reset_done", {d1, d0}, 64'd0);
    chk(rd0 == 0 && rd1 == 0 && !e0o && !e1o, "reset_resp", 64'(rd0), 64'd0);
    repeat (2) @(negedge clk);
    #2 hreset = 1'b0;
    @(negedge clk);

    fork
      run_req(0, NTX);
      run_req(1, NTX);
    join
    repeat (TO + 4) @(negedge clk);

    // Abandon a stalled transfer with an asynchronous reset.
    force_wait = 1'b1;
    issue(1, 1'b0);
    for (int t = 0; t < 50 && !(apb_if.psel && apb_if.penable); t++) @(negedge clk);
    chk(apb_if.psel && apb_if.penable, "reach_access", 64'(apb_if.penable), 64'd1);
    @(negedge clk);
    #2 hreset = 1'b1;
    #1;
    chk(!apb_if.psel && !apb_if.penable, "async_reset_bus", {apb_if.psel, apb_if.penable}, 64'd0);
    chk(!busy && !d0 && !d1, "async_reset_status", {busy, d1, d0}, 64'd0);
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    force_wait = 1'b0;
    @(negedge clk);
    #2 hreset = 1'b0;
    repeat (3) @(negedge clk);

    // Tie right after reset: requester 0 first, then requester 1.
    issue(0, 1'b0);
    issue(1, 1'b0);
    got0 = 1'b0;
    got1 = 1'b0;
    for (int t = 0; t < 100 && !(got0 && got1); t++) begin
      @(negedge clk);
      chk(!(d1 && !got0), "tie_order", 64'(d1), 64'd0);
      if (d0) begin got0 = 1'b1; req_v[0] = 1'b0; end
      if (d1) begin got1 = 1'b1; req_v[1] = 1'b0; end
    end
    chk(got0 && got1, "tie_both_done", {got1, got0}, 64'd3);
    repeat (3) @(negedge clk);
    chk(exp_q0.size() == 0 && exp_q1.size() == 0, "scoreboard_drained",
        64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, default 32, APB/requester address width.
REQ-002 The block SHALL have parameters: DATA_WIDTH, default 32, APB/requester data width.
REQ-003 The block SHALL have parameters: TIMEOUT, default 16, maximum ACCESS cycles before abort (>=2).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- hclk  in  1  clock, all state on rising edge
- hreset  in  1  asynchronous, active-high reset
REQ-005 Each requester port rN (N=0,1) SHALL carry:
- rN_req  in  1  transfer request, held until rN_done
- rN_write  in  1  1=write, 0=read
- rN_addr  in  ADDR_WIDTH  transfer address
- rN_wdata  in  DATA_WIDTH  write data
- rN_done  out  1  one-cycle completion pulse
- rN_rdata  out  DATA_WIDTH  read data, valid with rN_done
- rN_err  out  1  error flag, valid with rN_done
REQ-006 The APB master port SHALL carry:
- paddr  out  ADDR_WIDTH
- pwdata  out  DATA_WIDTH
- pwrite  out  1
- psel  out  1
- penable  out  1
- prdata  in  DATA_WIDTH
- pready  in  1
- pslverr  in  1
REQ-007 Status SHALL be provided on busy  out  1, high in SETUP and ACCESS.

Function
REQ-008 FSM states SHALL be IDLE, SETUP and ACCESS; all outputs are registered.
REQ-009 Grant in IDLE SHALL work as follows:
- Eligible requester: rN_req=1 and rN_done=0 in the same cycle (masks the cycle after completion).
- One eligible requester: it is granted.
- Two eligible requesters: the one not equal to last_grant is granted (round-robin).
- On a grant: go to SETUP, update last_grant, capture addr/write into paddr/pwrite, and set pwdata = wdata for writes, 0 for reads.
REQ-010 SETUP SHALL last exactly one cycle with psel=1, penable=0, then go to ACCESS.
REQ-011 ACCESS SHALL assert psel=1 and penable=1; paddr, pwrite and pwdata stay stable from SETUP to the end of ACCESS.
REQ-012 ACCESS with pready=1 SHALL complete the transfer:
- Next cycle: state IDLE, psel=0, penable=0.
- Granted rN_done=1 for one cycle.
- rN_rdata = prdata for reads, 0 for writes.
- rN_err = pslverr.
REQ-013 A timeout counter SHALL clear on SETUP and increment on each ACCESS cycle with pready=0.
- Counter reaches TIMEOUT-1 with pready=0: abort to IDLE with rN_done=1, rN_err=1, rN_rdata=0.
- ACCESS never lasts more than TIMEOUT cycles.
- pready=1 on the final cycle takes priority over timeout.
REQ-014 Latency: a request seen in IDLE at cycle N with pready=1 at first ACCESS SHALL give SETUP at N+1, ACCESS at N+2, done at N+3; the minimum spacing between transfers is 3 cycles.
REQ-015 Requests arriving during SETUP/ACCESS SHALL be ignored until IDLE; deasserting rN_req mid-transfer SHALL NOT abort it.
REQ-016 In IDLE, paddr, pwrite and pwdata SHALL hold their last values; rN_rdata and rN_err SHALL hold until the next rN_done.
REQ-017 The non-granted requester's done SHALL never be asserted; both done outputs SHALL never be high together.

Reset
REQ-018 hreset=1 SHALL immediately (asynchronously) apply:
- state=IDLE, last_grant=1 (requester 0 wins the first tie).
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- busy=0, counter=0.
- rN_done=0, rN_err=0, rN_rdata=0.
REQ-019 Reset during SETUP/ACCESS SHALL abandon the transfer without asserting any done; after release, arbitration restarts from REQ-009.

Verification
REQ-020 Single read:
- Stimulus: r0 read addr=0x10, pready=1 at first ACCESS, prdata=0xDEADBEEF.
- Response: psel at N+1, penable at N+2, r0_done at N+3 with r0_rdata=0xDEADBEEF, r0_err=0.
REQ-021 Simultaneous requests after reset:
- Stimulus: r0 and r1 held continuously.
- Response: grant order r0, r1, r0, r1; each completion spaced 3 cycles apart with pready=1.
REQ-022 Wait states:
- Stimulus: r1 write addr=0x20, wdata=0x1234, pready low for 3 ACCESS cycles then high.
- Response: paddr, pwdata and pwrite stable across all 4 ACCESS cycles; r1_done once.
REQ-023 Slave error and timeout:
- pslverr=1 with pready → r0_err=1.
- pready held 0 → abort after exactly TIMEOUT ACCESS cycles, r0_err=1, r0_rdata=0.
REQ-024 Reset mid-ACCESS:
- Stimulus: hreset pulsed during ACCESS.
- Response: psel and penable drop without a clock edge; no done pulse; next grant goes to r0 on a tie.
